// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in and classifies duty as 25/50/75 %.
// Optional macro PWM_CAP_GLITCH_FILTER_EN inserts a 3-sample majority filter before edge detection.
module pwm_capture #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TOL   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             dc_25,
  output logic             dc_50,
  output logic             dc_75,
  output logic             timeout
);

  localparam int unsigned CW = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CW-1:0]    TOL_EXT = CW'(TOL);
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int unsigned FILL_W = 6;
`else
  localparam int unsigned FILL_W = 3;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic              s1, s2, s3;
  logic              src, src_d;
  logic [FILL_W-1:0] fill;
  logic              edge_q;
  logic [CNT_W-1:0]  p_cnt, h_cnt;

  // fill marks which pipeline stages hold real samples, so reset zeros never look like an edge
`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic s4, filt, filt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      s4     <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      fill   <= '0;
      edge_q <= 1'b0;
    end else begin
      s1     <= pwm_in;
      s2     <= s1;
      s3     <= s2;
      s4     <= s3;
      filt   <= (s2 & s3) | (s2 & s4) | (s3 & s4);
      filt_d <= filt;
      fill   <= {fill[FILL_W-2:0], 1'b1};
      edge_q <= src & ~src_d & fill[FILL_W-1];
    end
  end

  assign src   = filt;
  assign src_d = filt_d;
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      fill   <= '0;
      edge_q <= 1'b0;
    end else begin
      s1     <= pwm_in;
      s2     <= s1;
      s3     <= s2;
      fill   <= {fill[FILL_W-2:0], 1'b1};
      edge_q <= src & ~src_d & fill[FILL_W-1];
    end
  end

  assign src   = s2;
  assign src_d = s3;
`endif

  // Duty classification on the counter values about to be captured
  function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [CW-1:0] h_ext, p_ext;
  logic          c25, c50, c75;

  always_comb begin
    h_ext = CW'(h_cnt);
    p_ext = CW'(p_cnt);
    c25   = absdiff(h_ext << 2, p_ext) <= TOL_EXT;
    c50   = absdiff(h_ext << 1, p_ext) <= TOL_EXT;
    c75   = absdiff(h_ext << 2, p_ext + (p_ext << 1)) <= TOL_EXT;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_q) state_d = RUN;
      RUN:     if (!edge_q && (p_cnt == CNT_MAX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge cycle is counted, so both counters restart at 1; src_d is the level aligned with edge_q
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_cnt      <= '0;
      h_cnt      <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      dc_25      <= 1'b0;
      dc_50      <= 1'b0;
      dc_75      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_q) begin
            p_cnt <= CNT_ONE;
            h_cnt <= CNT_ONE;
          end
        end
        RUN: begin
          if (edge_q) begin
            period_cnt <= p_cnt;
            high_cnt   <= h_cnt;
            dc_50      <= c50;
            dc_25      <= c25 & ~c50;
            dc_75      <= c75 & ~c50 & ~c25;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            p_cnt      <= CNT_ONE;
            h_cnt      <= CNT_ONE;
          end else if (p_cnt == CNT_MAX) begin
            timeout <= 1'b1;
            dc_25   <= 1'b0;
            dc_50   <= 1'b0;
            dc_75   <= 1'b0;
          end else begin
            p_cnt <= p_cnt + CNT_ONE;
            h_cnt <= h_cnt + CNT_W'(src_d);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM patterns push expected measurements,
// a negedge monitor pops them on meas_valid and checks output stability in between.
module tb_pwm_capture;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, dc_25, dc_50, dc_75, timeout;

  pwm_capture #(.CNT_W(CNT_W), .TOL(2)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
    .dc_25(dc_25), .dc_50(dc_50), .dc_75(dc_75), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] p;
    logic [2:0] f;   // {dc_75, dc_50, dc_25}
  } exp_t;

  exp_t        q[$];
  exp_t        pend, mon_e;
  bit          pend_valid = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_mv_cyc = 0;
  logic [7:0]  prev_h, prev_p;
  logic [2:0]  prev_f, exp_f;
  logic        prev_to;
  logic        rst_last = 1'b0;
  bit          found;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge at the start of this period completes the previous one
  task automatic pulse(input int h, input int l, input logic [2:0] f);
    if (pend_valid) q.push_back(pend);
    pend.h = 8'(h);
    pend.p = 8'(h + l);
    pend.f = f;
    pend_valid = 1;
    pwm_in = 1'b1;
    repeat (h) tick();
    pwm_in = 1'b0;
    repeat (l) tick();
  endtask

  always @(negedge clk) begin
    if (rst_last) begin
      n_vec++;
      if (meas_valid) begin
        last_mv_cyc = cyc;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_meas: got h=%0d p=%0d, required no meas_valid", high_cnt, period_cnt);
        end else begin
          mon_e = q.pop_front();
          if ({high_cnt, period_cnt, dc_75, dc_50, dc_25, timeout} !== {mon_e.h, mon_e.p, mon_e.f, 1'b0}) begin
            n_bad++;
            $display("FAIL meas: got h=%0d p=%0d dc75/50/25=%b to=%b, required h=%0d p=%0d dc=%b to=0",
                     high_cnt, period_cnt, {dc_75, dc_50, dc_25}, timeout, mon_e.h, mon_e.p, mon_e.f);
          end
        end
      end else begin
        exp_f = (timeout && !prev_to) ? 3'b000 : prev_f;
        if ({high_cnt, period_cnt, dc_75, dc_50, dc_25} !== {prev_h, prev_p, exp_f}) begin
          n_bad++;
          $display("FAIL hold: got h=%0d p=%0d dc=%b, required h=%0d p=%0d dc=%b",
                   high_cnt, period_cnt, {dc_75, dc_50, dc_25}, prev_h, prev_p, exp_f);
        end
      end
    end
    prev_h   = high_cnt;
    prev_p   = period_cnt;
    prev_f   = {dc_75, dc_50, dc_25};
    prev_to  = timeout;
    rst_last = rst;
  end

  task automatic check_zero(input string name);
    n_vec++;
    if ({high_cnt, period_cnt, meas_valid, dc_75, dc_50, dc_25, timeout} !== '0) begin
      n_bad++;
      $display("FAIL %s: got h=%0d p=%0d mv=%b dc=%b to=%b, required all 0",
               name, high_cnt, period_cnt, meas_valid, {dc_75, dc_50, dc_25}, timeout);
    end
  endtask

  task automatic check_to(input string name, input logic want);
    n_vec++;
    if (timeout !== want) begin
      n_bad++;
      $display("FAIL %s: got timeout=%b, required %b", name, timeout, want);
    end
  endtask

  initial begin
    rst    = 1'b0;
    pwm_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pwm_in = ~pwm_in;
      tick();
    end
    @(negedge clk);
    check_zero("reset_state");
    tick();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (10) tick();

    repeat (4) pulse(4, 12, 3'b001);
    repeat (3) pulse(8, 8, 3'b010);
    repeat (3) pulse(12, 4, 3'b100);
    repeat (3) pulse(4, 12, 3'b001);

    // Input stuck low: last 4/12 period never completes
    pend_valid = 0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) found = 1;
    end
    n_vec++;
    if (!found || (cyc - last_mv_cyc) != 255) begin
      n_bad++;
      $display("FAIL timeout_latency: got seen=%0d cycles=%0d, required seen=1 cycles=255", found, cyc - last_mv_cyc);
    end
    n_vec++;
    if ({high_cnt, period_cnt, dc_75, dc_50, dc_25, timeout} !== {8'd4, 8'd16, 3'b000, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_state: got h=%0d p=%0d dc=%b to=%b, required h=4 p=16 dc=000 to=1",
               high_cnt, period_cnt, {dc_75, dc_50, dc_25}, timeout);
    end
    tick();

    pulse(8, 8, 3'b010);
    check_to("timeout_after_first_edge", 1'b1);
    pulse(8, 8, 3'b010);
    pulse(8, 8, 3'b010);
    check_to("timeout_cleared", 1'b0);

    // Reset pulse in the middle of a high phase
    if (pend_valid) q.push_back(pend);
    pend_valid = 0;
    pwm_in = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    repeat (2) tick();
    pwm_in = 1'b0;
    repeat (8) tick();
    repeat (3) pulse(8, 8, 3'b010);

    // 1-cycle glitch inside a 16-cycle low phase
`ifdef PWM_CAP_GLITCH_FILTER_EN
    if (pend_valid) q.push_back(pend);
    pend.h = 8'd4;
    pend.p = 8'd20;
    pend.f = 3'b000;
    pend_valid = 1;
    pwm_in = 1'b1; repeat (4) tick();
    pwm_in = 1'b0; repeat (7) tick();
    pwm_in = 1'b1; tick();
    pwm_in = 1'b0; repeat (8) tick();
`else
    pulse(4, 7, 3'b000);
    pulse(1, 8, 3'b000);
`endif

    repeat (3) pulse(2, 2, 3'b010);
`ifndef PWM_CAP_GLITCH_FILTER_EN
    repeat (3) pulse(1, 1, 3'b010);
`endif
    repeat (2) pulse(64, 191, 3'b001);
    repeat (2) pulse(8, 8, 3'b010);
    repeat (30) tick();

    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_meas: got %0d pending expectations, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: high time and period in clock cycles, plus classification against the 25/50/75 % duty settings produced by `pwm_8`. It is the receive end of the PWM link. It sits on the input side of a board-level loopback or a remote PWM source, and reports one measurement per complete PWM period.

## Interface
Parameters:
- `CNT_W`, default 8: width of the cycle counters; the longest measurable period is 2^CNT_W−1 cycles.
- `TOL`, default 2: classification tolerance, in scaled units (see Operation).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `high_cnt`  out  CNT_W  high cycles in the last complete period.
- `period_cnt`  out  CNT_W  total cycles in the last complete period, rising edge to rising edge.
- `meas_valid`  out  1  one-cycle pulse when `high_cnt`/`period_cnt` update.
- `dc_25`, `dc_50`, `dc_75`  out  1 each  duty classification of the last measurement; held until the next update.
- `timeout`  out  1  sticky; no rising edge seen within 2^CNT_W−1 cycles.

## Operation
- **Input path:** `pwm_in` passes through a 2-flop synchronizer (s1, s2) and a delay flop s3. A rising edge is `s2 & ~s3`.
- **FSM states:**
  - IDLE: after reset or timeout; waits for a rising edge, then goes to RUN.
  - RUN: counts the period.
- **Counters in RUN:**
  - `p_cnt` counts every cycle.
  - `h_cnt` counts cycles with s2=1.
  - Both load 1 in the edge cycle, because the edge cycle itself is counted.
- **Second and later rising edges in RUN:**
  - `period_cnt` ← `p_cnt`, `high_cnt` ← `h_cnt`.
  - Flags are computed from these values.
  - `meas_valid`=1 for one cycle, `timeout` cleared.
  - Counters reload to 1.
- **First edge after IDLE:** never produces `meas_valid`, because the period is incomplete.
- **Timeout:** if `p_cnt` reaches 2^CNT_W−1 in RUN with no edge:
  - `timeout`←1; `dc_*` cleared; `high_cnt`/`period_cnt` hold.
  - FSM goes to IDLE.
  - A constant-high or constant-low input therefore always ends in timeout.
- **Classification:**
  - Arithmetic is unsigned, CNT_W+3 bits wide, with absolute differences. With H=high value and P=period value:
    - `dc_25` = |4H−P| ≤ TOL
    - `dc_50` = |2H−P| ≤ TOL
    - `dc_75` = |4H−3P| ≤ TOL
  - At most one flag is 1 when P ≥ 4·TOL. When several conditions match, priority is 50 > 25 > 75.
- **Reset:** rst=0 at any clock edge clears all state, including mid-period. Afterwards two rising edges are needed before the next `meas_valid`.
- **Reset values:** all outputs 0, FSM IDLE, s1/s2/s3 = 0.

## Timing
- **Latency:** `pwm_in` sampled 1 at edge k; s2=1 after edge k+1; edge detected in cycle k+2. Outputs and `meas_valid` are registered at edge k+3.
- **Output stability:** `high_cnt`, `period_cnt`, `dc_*` change only in the same cycle `meas_valid` is high.
- **Minimum period:** 2 cycles, which requires a high phase of at least 1 cycle and a low phase of at least 1 cycle as seen at s2.
- **Simultaneous events:** a rising edge in the same cycle `p_cnt` reaches max counts as a measurement, not a timeout.
- **Throughput:** back-to-back periods give one `meas_valid` per period with no dead cycles.

## Configuration
- `PWM_CAP_GLITCH_FILTER_EN`
- **Defined:** a 3-sample majority filter sits between s2 and the edge detector.
  - Adds 2 cycles of latency (`meas_valid` at edge k+5).
  - Pulses or gaps of 1 cycle are suppressed.
  - Counts are unchanged for phases of 2 or more cycles.
- **Undefined:** no filter; every 1-cycle pulse is a valid high phase and edge.

## Test plan
- Hold rst=0 for 5 cycles with `pwm_in` toggling → all outputs 0; no `meas_valid` until two rising edges after release.
- `pwm_in` 4 high / 12 low, repeated → from the second rising edge on, one `meas_valid` per period with `high_cnt`=4, `period_cnt`=16, `dc_25`=1 and other flags 0.
- 8/8 → `high_cnt`=8, `period_cnt`=16, `dc_50`=1. Then 12/4 → `high_cnt`=12, `dc_75`=1. Flags switch exactly on the `meas_valid` cycle.
- After a valid 4/12 stream, hold `pwm_in`=0 → exactly 255 cycles after the last edge, `timeout`=1, `dc_*`=0, and counts hold. On resuming 8/8, `timeout` clears on the second edge.
- Assert rst=0 for 1 cycle in the middle of a high phase → outputs clear; the next `meas_valid` comes only after two full edges and reports the correct 16-cycle period.
- 1-cycle high glitch inside a 16-cycle low phase:
  - With `PWM_CAP_GLITCH_FILTER_EN` → ignored, period unchanged.
  - Without it → an extra measurement with `high_cnt`=1.
